// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl: parametrised SM83 interrupt controller with IF/IE registers, delayed-EI IME and dispatch handshake.
// Fixed priority selects the lowest-index pending source; the vector holds until the next acknowledge.
module sm83_irq_ctrl #(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               if_wr_en,
  input  logic               ie_wr_en,
  input  logic [7:0]         wr_data,
  output logic [7:0]         if_rd_data,
  output logic [7:0]         ie_rd_data,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               instr_boundary,
  output logic               irq_take,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [15:0]        irq_vector,
  output logic               ime,
  output logic               wake
);
  typedef enum logic [1:0] {IME_OFF = 2'd0, IME_PEND = 2'd1, IME_ON = 2'd2} ime_e;
  typedef enum logic {D_IDLE = 1'b0, D_BUSY = 1'b1} dsp_e;
  logic [NUM_IRQ-1:0] if_q, if_d, ie_q, ie_d, pend, clr;
  ime_e               ime_q, ime_d;
  dsp_e               dsp_q, dsp_d;
  logic [15:0]        vec_q, vec_d;
  logic [2:0]         sel;
  logic               fire;
  logic               unused_wr;
  assign unused_wr = ^wr_data;
  assign pend = if_q & ie_q;
  assign fire = irq_ack && (dsp_q == D_IDLE);
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) sel = 3'(i);
  end
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      clr[i] = fire && (|pend) && (sel == 3'(i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q  <= '0;
      ie_q  <= '0;
      ime_q <= IME_OFF;
      dsp_q <= D_IDLE;
      vec_q <= '0;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      ime_q <= ime_d;
      dsp_q <= dsp_d;
      vec_q <= vec_d;
    end
  end
  // A request beats both the acknowledge clear and a CPU write in the same cycle.
  always_comb begin
    if_d  = irq_req | (~clr & (if_wr_en ? wr_data[NUM_IRQ-1:0] : if_q));
    ie_d  = ie_wr_en ? wr_data[NUM_IRQ-1:0] : ie_q;
    ime_d = (di || fire)                            ? IME_OFF  :
            reti                                    ? IME_ON   :
            (ime_q == IME_OFF && ei)                ? IME_PEND :
            (ime_q == IME_PEND && instr_boundary)   ? IME_ON   : ime_q;
    dsp_d = fire                                    ? D_BUSY   :
            (dsp_q == D_BUSY && irq_done)           ? D_IDLE   : dsp_q;
    vec_d = fire ? ((|pend) ? VEC_BASE + 16'(sel) * VEC_STRIDE : 16'h0000) : vec_q;
  end
  always_comb begin
    irq_take   = (ime_q == IME_ON) && (|pend) && (dsp_q == D_IDLE);
    wake       = |pend;
    ime        = ime_q == IME_ON;
    irq_vector = vec_q;
  end
  for (genvar i = 0; i < 8; i++) begin : g_rd
    if (i < NUM_IRQ) begin : g_src
      assign if_rd_data[i] = if_q[i];
      assign ie_rd_data[i] = ie_q[i];
    end else begin : g_pad
      assign if_rd_data[i] = 1'b1;
      assign ie_rd_data[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl: random and directed stimulus against a behavioural interrupt model, compared every cycle.
module tb_sm83_irq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [4:0]  irq_req;
  logic        if_wr_en, ie_wr_en, ei, di, reti, ib, ack, done;
  logic [7:0]  wr_data, if_rd, ie_rd;
  logic        take, ime, wake;
  logic [15:0] vec;
  logic [7:0]  b_req, b_wr, b_if_rd, b_ie_rd;
  logic        b_ie_wr, b_reti, b_ack, b_take, b_ime, b_wake;
  logic [15:0] b_vec;
  sm83_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .if_wr_en(if_wr_en), .ie_wr_en(ie_wr_en),
    .wr_data(wr_data), .if_rd_data(if_rd), .ie_rd_data(ie_rd), .ei(ei), .di(di), .reti(reti),
    .instr_boundary(ib), .irq_take(take), .irq_ack(ack), .irq_done(done), .irq_vector(vec),
    .ime(ime), .wake(wake)
  );
  sm83_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(16'h0040), .VEC_STRIDE(16'h0004)) dut8 (
    .clk(clk), .rst_n(rst_n), .irq_req(b_req), .if_wr_en(1'b0), .ie_wr_en(b_ie_wr),
    .wr_data(b_wr), .if_rd_data(b_if_rd), .ie_rd_data(b_ie_rd), .ei(1'b0), .di(1'b0), .reti(b_reti),
    .instr_boundary(1'b0), .irq_take(b_take), .irq_ack(b_ack), .irq_done(1'b0), .irq_vector(b_vec),
    .ime(b_ime), .wake(b_wake)
  );
  int checks = 0, failures = 0;
  bit chk_on = 0;
  bit [4:0]  m_if, m_ie;
  bit        m_on, m_arm, m_busy;
  bit [15:0] m_vec;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_if = 0; m_ie = 0; m_on = 0; m_arm = 0; m_busy = 0; m_vec = 0;
  endfunction
  function automatic void model_update();
    bit [4:0] pend, nif;
    int       sel;
    bit       fire;
    pend = m_if & m_ie;
    fire = ack && !m_busy;
    sel  = -1;
    for (int i = 4; i >= 0; i--) if (pend[i]) sel = i;
    for (int i = 0; i < 5; i++)
      nif[i] = irq_req[i] ? 1'b1 : (fire && i == sel) ? 1'b0 : if_wr_en ? wr_data[i] : m_if[i];
    if (ie_wr_en) m_ie = wr_data[4:0];
    if (di || fire) begin m_on = 0; m_arm = 0; end
    else if (reti) begin m_on = 1; m_arm = 0; end
    else if (m_arm && ib) begin m_on = 1; m_arm = 0; end
    else if (ei && !m_on) m_arm = 1;
    if (fire) begin
      m_busy = 1;
      m_vec  = (sel < 0) ? 16'h0000 : 16'h0040 + 16'(sel * 8);
    end else if (done) m_busy = 0;
    m_if = nif;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset(); else model_update();
  always @(negedge clk) if (chk_on) begin
    chk("if_rd", {8'h0, if_rd}, {8'h0, 3'b111, m_if});
    chk("ie_rd", {8'h0, ie_rd}, {11'h0, m_ie});
    chk("irq_take", {15'h0, take}, {15'h0, m_on && (m_if & m_ie) != 0 && !m_busy});
    chk("wake", {15'h0, wake}, {15'h0, (m_if & m_ie) != 0});
    chk("ime", {15'h0, ime}, {15'h0, m_on});
    chk("irq_vector", vec, m_vec);
  end
  task automatic cyc();
    @(posedge clk); #1;
    irq_req = 0; if_wr_en = 0; ie_wr_en = 0; wr_data = 0; ei = 0; di = 0; reti = 0; ib = 0;
    ack = 0; done = 0; b_req = 0; b_wr = 0; b_ie_wr = 0; b_reti = 0; b_ack = 0;
  endtask
  initial begin
    rst_n = 0;
    irq_req = 0; if_wr_en = 0; ie_wr_en = 0; wr_data = 0; ei = 0; di = 0; reti = 0; ib = 0;
    ack = 0; done = 0; b_req = 0; b_wr = 0; b_ie_wr = 0; b_reti = 0; b_ack = 0;
    #12;
    chk("rst if_rd", {8'h0, if_rd}, 16'h00E0);
    chk("rst ie_rd", {8'h0, ie_rd}, 16'h0000);
    chk("rst take/wake/ime", {13'h0, take, wake, ime}, 16'h0000);
    chk("rst8 if_rd", {8'h0, b_if_rd}, 16'h0000);
    rst_n = 1; chk_on = 1;
    cyc();
    ie_wr_en = 1; wr_data = 8'h1F; cyc();
    reti = 1; cyc();
    irq_req = 5'b00100; cyc();
    chk("basic take", {15'h0, take}, 16'h0001);
    chk("basic if", {8'h0, if_rd}, 16'h00E4);
    ack = 1; cyc();
    chk("basic if after ack", {8'h0, if_rd}, 16'h00E0);
    chk("basic ime", {15'h0, ime}, 16'h0000);
    chk("basic vec", vec, 16'h0050);
    done = 1; cyc();
    reti = 1; cyc();
    irq_req = 5'b10010; cyc();
    chk("prio take", {15'h0, take}, 16'h0001);
    ack = 1; cyc();
    chk("prio vec", vec, 16'h0048);
    chk("prio if", {8'h0, if_rd}, 16'h00F0);
    done = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no take before reti", {15'h0, take}, 16'h0000);
    end
    reti = 1; cyc();
    chk("take after reti", {15'h0, take}, 16'h0001);
    ack = 1; cyc();
    chk("second vec", vec, 16'h0060);
    done = 1; cyc();
    di = 1; cyc();
    ei = 1; ib = 1; cyc();
    chk("ei same-cycle boundary", {15'h0, ime}, 16'h0000);
    cyc();
    chk("ei waiting", {15'h0, ime}, 16'h0000);
    ib = 1; cyc();
    chk("ei after boundary", {15'h0, ime}, 16'h0001);
    di = 1; cyc();
    ei = 1; cyc();
    di = 1; cyc();
    ib = 1; cyc();
    chk("ei then di", {15'h0, ime}, 16'h0000);
    reti = 1; cyc();
    irq_req = 5'b00001; cyc();
    chk("cancel take", {15'h0, take}, 16'h0001);
    ie_wr_en = 1; wr_data = 8'h00; cyc();
    ack = 1; cyc();
    chk("cancel vec", vec, 16'h0000);
    chk("cancel if", {8'h0, if_rd}, 16'h00E1);
    chk("cancel ime", {15'h0, ime}, 16'h0000);
    done = 1; cyc();
    if_wr_en = 1; wr_data = 8'h00; irq_req = 5'b00010; cyc();
    chk("req beats write", {8'h0, if_rd}, 16'h00E2);
    ie_wr_en = 1; wr_data = 8'h1F; reti = 1; cyc();
    ack = 1; cyc();
    chk("busy vec", vec, 16'h0048);
    rst_n = 0; #2;
    chk("mid-busy rst if", {8'h0, if_rd}, 16'h00E0);
    chk("mid-busy rst ie", {8'h0, ie_rd}, 16'h0000);
    chk("mid-busy rst ime/take", {14'h0, ime, take}, 16'h0000);
    chk("mid-busy rst vec", vec, 16'h0000);
    rst_n = 1;
    cyc();
    ie_wr_en = 1; wr_data = 8'h1F; reti = 1; cyc();
    irq_req = 5'b00010; cyc();
    chk("idle after rst", {15'h0, take}, 16'h0001);
    ack = 1; cyc();
    done = 1; cyc();
    b_ie_wr = 1; b_wr = 8'hFF; b_reti = 1; cyc();
    b_req = 8'h80; cyc();
    chk("n8 take", {15'h0, b_take}, 16'h0001);
    b_ack = 1; cyc();
    chk("n8 vec", b_vec, 16'h005C);
    chk("n8 if", {8'h0, b_if_rd}, 16'h0000);
    chk("n8 ime", {15'h0, b_ime}, 16'h0000);
    for (int n = 0; n < 3000; n++) begin
      irq_req  = ($urandom_range(0, 3) == 0) ? 5'($urandom) & 5'($urandom) : 5'h0;
      if_wr_en = $urandom_range(0, 11) == 0;
      ie_wr_en = $urandom_range(0, 9) == 0;
      wr_data  = 8'($urandom);
      ei       = $urandom_range(0, 7) == 0;
      di       = $urandom_range(0, 19) == 0;
      reti     = $urandom_range(0, 14) == 0;
      ib       = $urandom_range(0, 2) == 0;
      ack      = $urandom_range(0, 2) == 0;
      done     = $urandom_range(0, 2) == 0;
      cyc();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; #2; rst_n = 1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
